// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the radix-2^D sequential multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wide enough to hold N/D itself, one past the last digit index.
  function automatic int unsigned cnt_width(input int unsigned n, input int unsigned d);
    return $clog2(n / d) + 1;
  endfunction

  function automatic bit legal_d(input int unsigned d);
    return (d == 1) || (d == 2) || (d == 4) || (d == 8);
  endfunction

endpackage

// File: rtl/mult_digit_pp.sv
// Combinational D-bit digit times N-bit multiplicand partial-product generator.
module mult_digit_pp #(
  parameter int unsigned N = 256,
  parameter int unsigned D = 4
) (
  input  logic [N-1:0]   mcand,
  input  logic [D-1:0]   digit,
  output logic [N+D-1:0] pp
);

  always_comb begin
    pp = {{D{1'b0}}, mcand} * {{N{1'b0}}, digit};
  end

endmodule

// File: rtl/seq_mult_rk.sv
// Sequential radix-2^D shift-and-add unsigned multiplier with valid/ready
// handshakes, early exit once the multiplier is exhausted, and synchronous flush.
module seq_mult_rk
  import mult_pkg::*;
#(
  parameter int unsigned N = 256,
  parameter int unsigned D = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] prod,
  output logic           busy
);

  localparam int unsigned   CW       = cnt_width(N, D);
  localparam logic [CW-1:0] LAST_CNT = CW'(N / D - 1);

  if (((N % D) != 0) || !legal_d(D)) begin : g_param_check
    $error("seq_mult_rk: N must be a multiple of D, and D one of 1, 2, 4, 8");
  end

  state_t           state;
  logic [N-1:0]     a_sh;
  logic [N-1:0]     a_nxt;
  logic [2*N-1:0]   b_sh;
  logic [2*N-1:0]   acc;
  logic [2*N+D-1:0] pp;
  logic [CW-1:0]    cnt;
  logic             last;

  // b_sh is already shifted into place, so the generator runs at 2N width;
  // its top D bits stay zero for every digit position reached in RUN.
  mult_digit_pp #(
    .N (2 * N),
    .D (D)
  ) u_pp (
    .mcand (b_sh),
    .digit (a_sh[D-1:0]),
    .pp    (pp)
  );

  always_comb begin
    a_nxt = a_sh >> D;
    last  = (cnt == LAST_CNT) || (a_nxt == '0);
  end

  always_comb begin
    if (state == RUN) begin
      assert (pp[2*N +: D] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= {{N{1'b0}}, b};
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc + pp[2*N-1:0];
          a_sh <= a_nxt;
          b_sh <= b_sh << D;
          cnt  <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == RUN);
    out_valid = (state == DONE);
    prod      = acc;
  end

endmodule

// File: tb/tb_seq_mult_rk.sv
// Self-checking bench for seq_mult_rk: directed N=256/D=4 scenarios plus
// randomized N=32 sweeps at D=1,2,8 against an arithmetic reference model.
module tb_seq_mult_rk;

  localparam int unsigned NB = 256;
  localparam int unsigned DB = 4;
  localparam int unsigned NS = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            iv, ir, fl, ov, ordy, busy;
  logic [NB-1:0]   a, b;
  logic [2*NB-1:0] prod;

  logic [2:0]                 s_iv, s_ir, s_fl, s_ov, s_ordy, s_busy;
  logic [2:0][NS-1:0]         s_a, s_b;
  logic [2:0][2*NS-1:0]       s_prod;

  int unsigned errors = 0;
  int unsigned checks = 0;

  seq_mult_rk #(.N(NB), .D(DB)) u_dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .flush(fl),
    .out_valid(ov), .out_ready(ordy), .prod(prod), .busy(busy)
  );

  seq_mult_rk #(.N(NS), .D(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(s_iv[0]), .in_ready(s_ir[0]), .a(s_a[0]), .b(s_b[0]),
    .flush(s_fl[0]), .out_valid(s_ov[0]), .out_ready(s_ordy[0]), .prod(s_prod[0]), .busy(s_busy[0])
  );

  seq_mult_rk #(.N(NS), .D(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(s_iv[1]), .in_ready(s_ir[1]), .a(s_a[1]), .b(s_b[1]),
    .flush(s_fl[1]), .out_valid(s_ov[1]), .out_ready(s_ordy[1]), .prod(s_prod[1]), .busy(s_busy[1])
  );

  seq_mult_rk #(.N(NS), .D(8)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(s_iv[2]), .in_ready(s_ir[2]), .a(s_a[2]), .b(s_b[2]),
    .flush(s_fl[2]), .out_valid(s_ov[2]), .out_ready(s_ordy[2]), .prod(s_prod[2]), .busy(s_busy[2])
  );

  // Reference model: plain arithmetic and the latency rule.
  function automatic logic [2*NB-1:0] ref_prod(input logic [NB-1:0] x, input logic [NB-1:0] y);
    return {{NB{1'b0}}, x} * {{NB{1'b0}}, y};
  endfunction

  function automatic int unsigned bitlen(input logic [NB-1:0] v);
    int unsigned n = 0;
    for (int unsigned i = 0; i < NB; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  function automatic int unsigned exp_lat(input int unsigned bl, input int unsigned d);
    return (bl == 0) ? 1 : (bl + d - 1) / d;
  endfunction

  // Stimulus helpers (no checking): all tests run at 1 time unit after a rising edge.
  task automatic accept_256(input logic [NB-1:0] av, input logic [NB-1:0] bv);
    for (int i = 0; i < 300 && !ir; i++) begin
      @(posedge clk); #1;
    end
    iv = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    iv = 1'b0; a = ~av; b = ~bv;
  endtask

  task automatic wait_ov_256(output int unsigned lat);
    lat = 0;
    while (!ov && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++;
    if ({ir, ov, busy} !== 3'b100) begin
      errors++; $display("FAIL reset_flags: got ir/ov/busy=%b expected 100", {ir, ov, busy});
    end
    checks++;
    if (prod !== '0) begin
      errors++; $display("FAIL reset_prod: got %0h expected 0", prod);
    end
    checks++;
    if (s_ir !== 3'b111 || s_ov !== 3'b000 || s_busy !== 3'b000) begin
      errors++; $display("FAIL reset_sweep_flags: got ir=%b ov=%b busy=%b expected 111 000 000", s_ir, s_ov, s_busy);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_width;
    logic [2*NB-1:0] e;
    int unsigned lat;
    e = '1;
    e[NB:1] = '0;
    ordy = 1'b1;
    accept_256('1, '1);
    checks++;
    if (busy !== 1'b1 || ir !== 1'b0) begin
      errors++; $display("FAIL full_busy: got busy=%b ir=%b expected 1 0", busy, ir);
    end
    wait_ov_256(lat);
    checks++;
    if (lat !== 64) begin
      errors++; $display("FAIL full_latency: got %0d expected 64", lat);
    end
    checks++;
    if (prod !== e) begin
      errors++; $display("FAIL full_prod: got %0h expected %0h", prod, e);
    end
    @(posedge clk); #1;
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1) begin
      errors++; $display("FAIL full_handoff: got ov=%b ir=%b expected 0 1", ov, ir);
    end
    ordy = 1'b0;
  endtask

  task automatic test_early_exit;
    logic [NB-1:0] ta[3];
    logic [NB-1:0] tb[3];
    int unsigned   tl[3];
    int unsigned   lat;
    ta = '{256'h13, 256'h0, 256'h100};
    tb = '{256'hFFFF, 256'h1234_5678, 256'h0};
    tl = '{2, 1, 3};
    ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      accept_256(ta[i], tb[i]);
      wait_ov_256(lat);
      checks++;
      if (lat !== tl[i]) begin
        errors++; $display("FAIL early_latency[%0d]: got %0d expected %0d", i, lat, tl[i]);
      end
      checks++;
      if (prod !== ref_prod(ta[i], tb[i])) begin
        errors++; $display("FAIL early_prod[%0d]: got %0h expected %0h", i, prod, ref_prod(ta[i], tb[i]));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ir !== 1'b1) begin
      errors++; $display("FAIL early_idle: got ir=%b expected 1", ir);
    end
    ordy = 1'b0;
  endtask

  task automatic test_hold;
    int unsigned lat;
    ordy = 1'b0;
    accept_256(256'd5, 256'd7);
    wait_ov_256(lat);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL hold_latency: got %0d expected 1", lat);
    end
    for (int i = 0; i < 10; i++) begin
      a = NB'($urandom); b = NB'($urandom);
      @(posedge clk); #1;
      checks++;
      if (ov !== 1'b1 || ir !== 1'b0 || prod !== 512'd35) begin
        errors++; $display("FAIL hold_stable[%0d]: got ov=%b ir=%b prod=%0h expected 1 0 23", i, ov, ir, prod);
      end
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_release: got ov=%b ir=%b busy=%b expected 0 1 0", ov, ir, busy);
    end
    ordy = 1'b0;
  endtask

  task automatic test_flush;
    int unsigned lat;
    int unsigned seen;
    ordy = 1'b1;
    accept_256('1, '1);
    repeat (9) begin @(posedge clk); #1; end
    fl = 1'b1;
    @(posedge clk); #1;
    fl = 1'b0;
    checks++;
    if (ir !== 1'b1 || busy !== 1'b0 || ov !== 1'b0) begin
      errors++; $display("FAIL flush_run: got ir=%b busy=%b ov=%b expected 1 0 0", ir, busy, ov);
    end
    seen = 0;
    repeat (80) begin @(posedge clk); #1; if (ov) seen++; end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL flush_no_output: got %0d out_valid cycles expected 0", seen);
    end
    accept_256(256'd3, 256'd3);
    wait_ov_256(lat);
    checks++;
    if (prod !== 512'd9 || lat !== 1) begin
      errors++; $display("FAIL flush_fresh: got prod=%0h lat=%0d expected 9 1", prod, lat);
    end
    @(posedge clk); #1;
    // flush beats a simultaneous accept
    fl = 1'b1; iv = 1'b1; a = 256'd3; b = 256'd3;
    @(posedge clk); #1;
    fl = 1'b0; iv = 1'b0;
    checks++;
    if (ir !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_vs_accept: got ir=%b busy=%b expected 1 0", ir, busy);
    end
    // flush discards a held result
    ordy = 1'b0;
    accept_256(256'd5, 256'd7);
    wait_ov_256(lat);
    fl = 1'b1;
    @(posedge clk); #1;
    fl = 1'b0;
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1) begin
      errors++; $display("FAIL flush_done: got ov=%b ir=%b expected 0 1", ov, ir);
    end
  endtask

  task automatic test_async_reset;
    int unsigned lat;
    int unsigned seen;
    ordy = 1'b1;
    accept_256('1, '1);
    repeat (5) begin @(posedge clk); #1; end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({ir, ov, busy} !== 3'b100 || prod !== '0) begin
      errors++; $display("FAIL areset_run: got ir/ov/busy=%b prod=%0h expected 100 0", {ir, ov, busy}, prod);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    seen = 0;
    repeat (80) begin @(posedge clk); #1; if (ov || busy) seen++; end
    checks++;
    if (seen !== 0 || ir !== 1'b1) begin
      errors++; $display("FAIL areset_after: got %0d active cycles ir=%b expected 0 1", seen, ir);
    end
    ordy = 1'b0;
    accept_256(256'd5, 256'd7);
    wait_ov_256(lat);
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1 || prod !== '0) begin
      errors++; $display("FAIL areset_done: got ov=%b ir=%b prod=%0h expected 0 1 0", ov, ir, prod);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [NB-1:0]   a1, b1, a2, b2;
    logic [2*NB-1:0] got;
    int unsigned     n, lat;
    a1 = 256'h1234; b1 = 256'h55;
    a2 = 256'hFF;   b2 = 256'h3;
    ordy = 1'b1;
    iv = 1'b1; a = a1; b = b1;
    @(posedge clk); #1;
    a = a2; b = b2;
    n = 0; got = '0;
    while (!ir && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (ov) got = prod;
    end
    checks++;
    if (n !== exp_lat(bitlen(a1), DB) + 1) begin
      errors++; $display("FAIL b2b_ready_gap: got %0d expected %0d", n, exp_lat(bitlen(a1), DB) + 1);
    end
    checks++;
    if (got !== ref_prod(a1, b1)) begin
      errors++; $display("FAIL b2b_prod1: got %0h expected %0h", got, ref_prod(a1, b1));
    end
    @(posedge clk); #1;
    iv = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_second_accept: got busy=%b expected 1", busy);
    end
    wait_ov_256(lat);
    checks++;
    if (lat !== exp_lat(bitlen(a2), DB) || prod !== ref_prod(a2, b2)) begin
      errors++; $display("FAIL b2b_prod2: got prod=%0h lat=%0d expected %0h %0d", prod, lat, ref_prod(a2, b2), exp_lat(bitlen(a2), DB));
    end
    @(posedge clk); #1;
    ordy = 1'b0;
  endtask

  task automatic test_sweep(input int k, input int unsigned d);
    logic [NS-1:0] av, bv;
    int unsigned   l, lat, el;
    s_ordy[k] = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      l  = $urandom_range(0, NS);
      av = NS'($urandom) & ((NS'(1) << l) - NS'(1));
      if (l == NS) av = NS'($urandom);
      if (l != 0) av[l-1] = 1'b1;
      bv = ($urandom_range(0, 19) == 0) ? '0 : NS'($urandom);
      for (int i = 0; i < 300 && !s_ir[k]; i++) begin @(posedge clk); #1; end
      s_iv[k] = 1'b1; s_a[k] = av; s_b[k] = bv;
      @(posedge clk); #1;
      s_iv[k] = 1'b0; s_a[k] = NS'($urandom); s_b[k] = NS'($urandom);
      checks++;
      if (s_busy[k] !== 1'b1) begin
        errors++; $display("FAIL sweep_d%0d_busy[%0d]: got %b expected 1", d, t, s_busy[k]);
      end
      lat = 0;
      while (!s_ov[k] && lat < 300) begin @(posedge clk); #1; lat++; end
      el = exp_lat(bitlen(NB'(av)), d);
      checks++;
      if (lat !== el) begin
        errors++; $display("FAIL sweep_d%0d_latency[%0d]: a=%0h got %0d expected %0d", d, t, av, lat, el);
      end
      checks++;
      if (s_prod[k] !== 64'(av) * 64'(bv)) begin
        errors++; $display("FAIL sweep_d%0d_prod[%0d]: a=%0h b=%0h got %0h expected %0h", d, t, av, bv, s_prod[k], 64'(av) * 64'(bv));
      end
      @(posedge clk); #1;
    end
    s_ordy[k] = 1'b0;
  endtask

  initial begin
    iv = 1'b0; fl = 1'b0; ordy = 1'b0; a = '0; b = '0;
    s_iv = '0; s_fl = '0; s_ordy = '0; s_a = '0; s_b = '0;
    test_reset;
    test_full_width;
    test_early_exit;
    test_hold;
    test_flush;
    test_async_reset;
    test_back_to_back;
    test_sweep(0, 1);
    test_sweep(1, 2);
    test_sweep(2, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
